// File: rtl/max7219_rx_pkg.sv
// Shared constants for the MAX7219 serial receiver: FSM states, register addresses and frame width.
package max7219_rx_pkg;

   localparam int C_FRAME_W = 16;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_LATCH = 2'd2;

   localparam logic [3:0] C_ADDR_NOOP         = 4'h0;
   localparam logic [3:0] C_ADDR_DIGIT0       = 4'h1;
   localparam logic [3:0] C_ADDR_DIGIT7       = 4'h8;
   localparam logic [3:0] C_ADDR_DECODE_MODE  = 4'h9;
   localparam logic [3:0] C_ADDR_INTENSITY    = 4'hA;
   localparam logic [3:0] C_ADDR_SCAN_LIMIT   = 4'hB;
   localparam logic [3:0] C_ADDR_SHUTDOWN     = 4'hC;
   localparam logic [3:0] C_ADDR_DISPLAY_TEST = 4'hF;

endpackage

// File: rtl/max7219_rx_sync.sv
// Multi-stage synchronizer for one asynchronous input followed by a single-flop rise/fall detector.
module max7219_rx_sync #(
   parameter int   DEPTH   = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [DEPTH-1:0] chain;
   logic             prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {DEPTH{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[DEPTH-2:0], async_in};
         prev  <= chain[DEPTH-1];
      end
   end

   assign level = chain[DEPTH-1];
   assign rise  = chain[DEPTH-1] & ~prev;
   assign fall  = ~chain[DEPTH-1] & prev;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 serial-frame receiver mirroring the chip's digit and control registers.
// Optional daisy-chain output o_max7219_dout is built when MAX7219_RX_DOUT_EN is defined.
module max7219_rx
   import max7219_rx_pkg::*;
#(
   parameter int G_SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_max7219_clk,
   input  logic        i_max7219_din,
   input  logic        i_max7219_load,
   output logic        o_frame_valid,
   output logic        o_frame_err,
   output logic [3:0]  o_addr,
   output logic [7:0]  o_data,
   output logic [63:0] o_digits,
   output logic [7:0]  o_decode_mode,
   output logic [3:0]  o_intensity,
   output logic [2:0]  o_scan_limit,
   output logic        o_shutdown_n,
   output logic        o_display_test
`ifdef MAX7219_RX_DOUT_EN
   ,
   output logic        o_max7219_dout
`endif
);

   logic                 sclk_level, sclk_rise, sclk_fall;
   logic                 din_level, din_rise, din_fall;
   logic                 load_level, load_rise, load_fall;
   logic [1:0]           state;
   logic [4:0]           cnt;
   logic [C_FRAME_W-1:0] shreg;
   logic [2:0]           digit_idx;
   logic                 unused_sig;

   max7219_rx_sync #(.DEPTH(G_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
      .clk(clk), .rst(rst), .async_in(i_max7219_clk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));

   max7219_rx_sync #(.DEPTH(G_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
      .clk(clk), .rst(rst), .async_in(i_max7219_din),
      .level(din_level), .rise(din_rise), .fall(din_fall));

   // LOAD idles high, so its synchronizer resets high to avoid a phantom fall.
   max7219_rx_sync #(.DEPTH(G_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
      .clk(clk), .rst(rst), .async_in(i_max7219_load),
      .level(load_level), .rise(load_rise), .fall(load_fall));

   assign digit_idx = shreg[10:8] - 3'd1;

`ifdef MAX7219_RX_DOUT_EN
   assign unused_sig = ^{sclk_level, din_rise, din_fall, load_level, shreg[14:12]};

   always_ff @(posedge clk) begin
      if (rst)            o_max7219_dout <= 1'b0;
      else if (sclk_fall) o_max7219_dout <= shreg[15];
   end
`else
   assign unused_sig = ^{sclk_level, sclk_fall, din_rise, din_fall, load_level, shreg[15:12]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= 5'd0;
         shreg          <= '0;
         o_frame_valid  <= 1'b0;
         o_frame_err    <= 1'b0;
         o_addr         <= 4'h0;
         o_data         <= 8'h00;
         o_digits       <= 64'h0;
         o_decode_mode  <= 8'h00;
         o_intensity    <= 4'h0;
         o_scan_limit   <= 3'd0;
         o_shutdown_n   <= 1'b0;
         o_display_test <= 1'b0;
      end else begin
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_fall) begin
                  state <= S_SHIFT;
                  cnt   <= 5'd0;
                  shreg <= '0;
               end
            end
            S_SHIFT: begin
               // A clock edge coinciding with LOAD rise still contributes its bit.
               if (sclk_rise) begin
                  shreg <= {shreg[C_FRAME_W-2:0], din_level};
                  if (cnt != 5'd31) cnt <= cnt + 5'd1;
               end
               if (load_rise) state <= S_LATCH;
            end
            S_LATCH: begin
               state       <= S_IDLE;
               o_frame_err <= (cnt != 5'd16);
               if (cnt >= 5'd16) begin
                  o_frame_valid <= 1'b1;
                  o_addr        <= shreg[11:8];
                  o_data        <= shreg[7:0];
                  if (shreg[11:8] >= C_ADDR_DIGIT0 && shreg[11:8] <= C_ADDR_DIGIT7) begin
                     o_digits[{digit_idx, 3'b000} +: 8] <= shreg[7:0];
                  end else begin
                     case (shreg[11:8])
                        C_ADDR_DECODE_MODE:  o_decode_mode  <= shreg[7:0];
                        C_ADDR_INTENSITY:    o_intensity    <= shreg[3:0];
                        C_ADDR_SCAN_LIMIT:   o_scan_limit   <= shreg[2:0];
                        C_ADDR_SHUTDOWN:     o_shutdown_n   <= shreg[0];
                        C_ADDR_DISPLAY_TEST: o_display_test <= shreg[0];
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx: frames are driven serially, expected pulses go into a queue
// and a negedge monitor pops and compares whenever the receiver reports a frame.
module tb_max7219_rx;

   localparam int SYNC = 2;
   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk, din, load;
   logic        frame_valid, frame_err;
   logic [3:0]  addr;
   logic [7:0]  data;
   logic [63:0] digits;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic        shutdown_n, display_test;
`ifdef MAX7219_RX_DOUT_EN
   logic        dout;
`endif

   // {valid, err, addr, data}
   logic [13:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   max7219_rx #(.G_SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst),
      .i_max7219_clk(sclk), .i_max7219_din(din), .i_max7219_load(load),
      .o_frame_valid(frame_valid), .o_frame_err(frame_err),
      .o_addr(addr), .o_data(data), .o_digits(digits),
      .o_decode_mode(decode_mode), .o_intensity(intensity), .o_scan_limit(scan_limit),
      .o_shutdown_n(shutdown_n), .o_display_test(display_test)
`ifdef MAX7219_RX_DOUT_EN
      , .o_max7219_dout(dout)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && (frame_valid || frame_err)) begin
         logic [13:0] e;
         logic [13:0] a;
         a = {frame_valid, frame_err, addr, data};
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse: got %0h with empty queue", a);
         end else begin
            e = exp_q.pop_front();
            if (e[13]) check("frame", {50'h0, a}, {50'h0, e});
            else       check("err_only", {62'h0, a[13:12]}, {62'h0, e[13:12]});
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         din = bits[i];
         cycles(HOLD);
         sclk = 1'b1;
         cycles(HOLD);
         sclk = 1'b0;
         cycles(HOLD);
      end
   endtask

   task automatic send_frame(input logic [31:0] bits, input int n);
      load = 1'b0;
      cycles(HOLD);
      send_bits(bits, n);
      load = 1'b1;
      cycles(12);
   endtask

   initial begin
      int lat;
      rst = 1'b1; sclk = 1'b0; din = 1'b0; load = 1'b1;
      cycles(5);
      rst = 1'b0;
      cycles(2);

      check("rst_shutdown_n", {63'h0, shutdown_n}, 64'h0);
      check("rst_digits", digits, 64'h0);
      check("rst_ctrl", {44'h0, decode_mode, intensity, scan_limit, display_test, addr, data}, 64'h0);

      // Intensity frame with latency measurement from LOAD rise
      exp_q.push_back({2'b10, 4'hA, 8'h05});
      load = 1'b0;
      cycles(HOLD);
      send_bits(32'h0A05, 16);
      load = 1'b1;
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (frame_valid && lat < 0) lat = k;
      end
      check("valid_latency", lat, SYNC + 2);
      check("intensity_a", {60'h0, intensity}, 64'h5);
      cycles(2);

      // Eight digit frames, digit n-1 = 0x11*n
      for (int n = 1; n <= 8; n++) begin
         logic [7:0] v;
         v = 8'(8'h11 * n);
         exp_q.push_back({2'b10, 4'(n), v});
         send_frame({16'h0, 4'h0, 4'(n), v}, 16);
      end
      check("digits_all", digits, 64'h8877665544332211);

      // Short frame: error only, registers untouched
      exp_q.push_back({2'b01, 12'h000});
      send_frame(32'hABC, 12);
      check("short_addr_data", {52'h0, addr, data}, 64'h888);
      check("short_intensity", {60'h0, intensity}, 64'h5);
      check("short_digits", digits, 64'h8877665544332211);

      // Long frame: commit last 16 bits and flag error
      exp_q.push_back({2'b11, 4'hC, 8'h01});
      send_frame(32'hF0C01, 20);
      check("long_shutdown_n", {63'h0, shutdown_n}, 64'h1);

      // Serial clocks while LOAD is high must not count
      send_bits(32'hF, 4);
      exp_q.push_back({2'b10, 4'hA, 8'h0C});
      send_frame(32'h0A0C, 16);
      check("idle_edges_intensity", {60'h0, intensity}, 64'hC);

      // Address 0xD leaves every register alone
      exp_q.push_back({2'b10, 4'hD, 8'hFF});
      send_frame(32'h0DFF, 16);
      check("addr_d_ctrl", {49'h0, decode_mode, intensity, scan_limit}, {49'h0, 8'h00, 4'hC, 3'd0});
      check("addr_d_digits", digits, 64'h8877665544332211);

      // Last serial clock rise coincides with LOAD rise
      exp_q.push_back({2'b10, 4'h9, 8'h03});
      load = 1'b0;
      cycles(HOLD);
      send_bits(32'h0903 >> 1, 15);
      din = 1'b1;
      cycles(HOLD);
      sclk = 1'b1;
      load = 1'b1;
      cycles(HOLD);
      sclk = 1'b0;
      cycles(12);
      check("same_edge_decode", {56'h0, decode_mode}, 64'h03);

      // Reset in the middle of frame 0x0F01, then a clean 0x0B07
      load = 1'b0;
      cycles(HOLD);
      send_bits(32'h0F, 8);
      rst = 1'b1;
      cycles(2);
      load = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(8);
      check("mid_rst_digits", digits, 64'h0);
      check("mid_rst_shutdown_n", {63'h0, shutdown_n}, 64'h0);
      exp_q.push_back({2'b10, 4'hB, 8'h07});
      send_frame(32'h0B07, 16);
      check("mid_rst_scan_test", {60'h0, scan_limit, display_test}, {60'h0, 3'd7, 1'b0});

`ifdef MAX7219_RX_DOUT_EN
      // Two frames under one LOAD low: the first frame shifts out on dout
      exp_q.push_back({2'b11, 4'h2, 8'h03});
      load = 1'b0;
      cycles(HOLD);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] pat;
         logic [15:0] first;
         pat = 32'h0102_0203;
         first = 16'h0102;
         din = pat[31-i];
         cycles(HOLD);
         if (i >= 16) check("dout_bit", {63'h0, dout}, {63'h0, first[31-i]});
         sclk = 1'b1;
         cycles(HOLD);
         sclk = 1'b0;
         cycles(HOLD);
      end
      load = 1'b1;
      cycles(12);
      check("dout_digits", digits, 64'h0300);
`endif

      cycles(20);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
